// File: rtl/multicycle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multicycle_pkg                                             |
// | Brief   : State encoding and opcode constants for multicycle_seq     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package multicycle_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [2:0] OP_LW   = 3'b000;
    localparam logic [2:0] OP_SW   = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

    // Opcodes 110 and 111 are unassigned.
    function automatic logic is_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_seq_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wait_timer                                                 |
// | Brief   : Counts memory-request wait cycles, flags expiry at         |
// |           TIMEOUT-1                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    // Wait counter: clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= 8'd0;
        end else if (en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expire = (r_count == LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multicycle_seq                                             |
// | Brief   : Multicycle CPU control sequencer with memory timeout       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multicycle_seq
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       jmp,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] state
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic       w_expire;
    logic       w_clr;
    logic       w_en;
    logic       w_in_mem;

    // Timer only runs in the two request states; any ack or expiry ends the wait.
    assign w_in_mem = (r_state == FETCH) || (r_state == MEM);
    assign w_clr    = !w_in_mem || mem_ack || w_expire;
    assign w_en     = mem_req && !mem_ack;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .en     (w_en),
        .expire (w_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode latch: captured in DECODE so later input changes cannot disturb the instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= 3'd0;
        end else if (r_state == DECODE) begin
            r_op <= opcode;
        end
    end

    // Next-state logic; ack beats a coincident timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: begin
                if (mem_ack)       w_next = DECODE;
                else if (w_expire) w_next = FETCH;
            end
            DECODE: begin
                w_next = is_illegal(opcode) ? FETCH : EXEC;
            end
            EXEC: begin
                if (r_op == OP_J)                         w_next = FETCH;
                else if (r_op == OP_LW || r_op == OP_SW)  w_next = MEM;
                else                                      w_next = WB;
            end
            MEM: begin
                if (mem_ack)       w_next = (r_op == OP_LW) ? WB : FETCH;
                else if (w_expire) w_next = FETCH;
            end
            WB:      w_next = FETCH;
            default: w_next = FETCH;
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        jmp        = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        if (!rst) begin
            case (r_state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end else if (w_expire) begin
                        mem_err = 1'b1;
                    end
                end
                DECODE: begin
                    illegal = is_illegal(opcode);
                end
                EXEC: begin
                    if (r_op == OP_J) begin
                        jmp        = 1'b1;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                    end else begin
                        alu_src = (r_op != OP_ADD) && (r_op != OP_SUB);
                        alu_op  = (r_op == OP_SUB);
                    end
                end
                MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    alu_src = 1'b1;
                    if (mem_ack) begin
                        mem_we     = (r_op == OP_SW);
                        instr_done = (r_op == OP_SW);
                    end else if (w_expire) begin
                        mem_err = 1'b1;
                    end else begin
                        mem_we = (r_op == OP_SW);
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    mem_to_reg = (r_op == OP_LW);
                    alu_src    = (r_op != OP_ADD) && (r_op != OP_SUB);
                    alu_op     = (r_op == OP_SUB);
                end
                default: ;
            endcase
        end
    end

    assign state = rst ? FETCH : r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_multicycle_seq                                          |
// | Brief   : Self-checking bench for multicycle_seq                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_multicycle_seq;

    localparam int TO = 4;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4;
    localparam logic [2:0] LW = 3'd0, SW = 3'd1, J = 3'd2, ADD = 3'd3,
                           ADDI = 3'd4, SUB = 3'd5;

    localparam logic [12:0] M_REQ  = 13'h1000, M_WE   = 13'h0800, M_IORD = 13'h0400,
                            M_IRW  = 13'h0200, M_PCW  = 13'h0100, M_JMP  = 13'h0080,
                            M_ASRC = 13'h0040, M_M2R  = 13'h0020, M_REG  = 13'h0010,
                            M_ALUOP= 13'h0008, M_DONE = 13'h0004, M_ILL  = 13'h0002,
                            M_ERR  = 13'h0001;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       mem_ack;
    logic       mem_req, mem_we, iord, ir_write, pc_write, jmp, alu_src;
    logic       mem_to_reg, reg_write, alu_op, instr_done, illegal, mem_err;
    logic [2:0] state;
    logic [12:0] outv;

    int vectors;
    int miscompares;

    multicycle_seq #(
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .jmp        (jmp),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal    (illegal),
        .mem_err    (mem_err),
        .state      (state)
    );

    assign outv = {mem_req, mem_we, iord, ir_write, pc_write, jmp, alu_src,
                   mem_to_reg, reg_write, alu_op, instr_done, illegal, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs, check at the falling edge, move past the next rising edge.
    task automatic step(input logic a, input logic [2:0] op, input logic r,
                        input logic [12:0] ev, input logic [2:0] es);
        mem_ack = a;
        opcode  = op;
        rst     = r;
        @(negedge clk);
        vectors++;
        assert (outv === ev) else begin
            miscompares++;
            $error("FAIL outputs got=%h exp=%h (st=%0d ack=%b rst=%b)", outv, ev, es, a, r);
        end
        vectors++;
        assert (state === es) else begin
            miscompares++;
            $error("FAIL state got=%0d exp=%0d", state, es);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] rop();
        return 3'($urandom);
    endfunction

    function automatic logic rack();
        return 1'($urandom);
    endfunction

    // Reference: one instruction as a recipe of cycles. fw / mw = idle request
    // cycles before the ack; a value >= TO means the ack never arrives in time.
    task automatic run_instr(input logic [2:0] op, input int fw, input int mw);
        bit          acked;
        logic [12:0] aluv;
        logic [12:0] memv;
        acked = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if (i == fw) begin
                step(1'b1, rop(), 1'b0, M_REQ | M_IRW | M_PCW, S_FETCH);
                acked = 1'b1;
                break;
            end else if (i == TO - 1) begin
                step(1'b0, rop(), 1'b0, M_REQ | M_ERR, S_FETCH);
            end else begin
                step(1'b0, rop(), 1'b0, M_REQ, S_FETCH);
            end
        end
        if (!acked) return;

        if (op == 3'd6 || op == 3'd7) begin
            step(rack(), op, 1'b0, M_ILL, S_DECODE);
            return;
        end
        step(rack(), op, 1'b0, 13'h0, S_DECODE);

        if (op == J) begin
            step(rack(), rop(), 1'b0, M_JMP | M_PCW | M_DONE, S_EXEC);
            return;
        end
        aluv = (op == SUB) ? M_ALUOP : (op == ADD) ? 13'h0 : M_ASRC;
        step(rack(), rop(), 1'b0, aluv, S_EXEC);

        if (op == LW || op == SW) begin
            memv = M_REQ | M_IORD | M_ASRC;
            acked = 1'b0;
            for (int i = 0; i < TO; i++) begin
                if (i == mw) begin
                    step(1'b1, rop(), 1'b0, memv | ((op == SW) ? (M_WE | M_DONE) : 13'h0), S_MEM);
                    acked = 1'b1;
                    break;
                end else if (i == TO - 1) begin
                    step(1'b0, rop(), 1'b0, memv | M_ERR, S_MEM);
                end else begin
                    step(1'b0, rop(), 1'b0, memv | ((op == SW) ? M_WE : 13'h0), S_MEM);
                end
            end
            if (!acked || op == SW) return;
        end

        step(rack(), rop(), 1'b0, M_REG | M_DONE | aluv | ((op == LW) ? M_M2R : 13'h0), S_WB);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        mem_ack = 1'b0;
        opcode  = 3'd0;

        // Reset: everything low, state reads FETCH, even with ack asserted.
        step(1'b0, 3'd0, 1'b1, 13'h0, S_FETCH);
        step(1'b1, 3'd0, 1'b1, 13'h0, S_FETCH);

        // Directed: add, lw with late data ack, sw, j, illegal, timeouts.
        run_instr(ADD, 0, 0);
        run_instr(LW, 0, 2);
        run_instr(SW, 0, 0);
        run_instr(J, 0, 0);
        run_instr(3'd7, 0, 0);
        run_instr(SUB, 1, 0);
        run_instr(ADDI, 0, 0);
        run_instr(ADD, TO, 0);
        run_instr(ADD, TO - 1, 0);
        run_instr(SW, 0, TO);
        run_instr(LW, 0, TO - 1);

        // Reset in the 2nd cycle of a pending lw data access.
        step(1'b1, rop(), 1'b0, M_REQ | M_IRW | M_PCW, S_FETCH);
        step(1'b0, LW, 1'b0, 13'h0, S_DECODE);
        step(1'b0, rop(), 1'b0, M_ASRC, S_EXEC);
        step(1'b0, rop(), 1'b0, M_REQ | M_IORD | M_ASRC, S_MEM);
        step(1'b1, rop(), 1'b1, 13'h0, S_FETCH);
        step(1'b0, rop(), 1'b0, M_REQ, S_FETCH);
        step(1'b0, rop(), 1'b1, 13'h0, S_FETCH);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            run_instr(3'($urandom), $urandom_range(0, TO + 1), $urandom_range(0, TO + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
